// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among REQ_NUM requesters.
// Each grant is a burst of up to BURST_LEN words, throttled per word by fifo_full.
module fifo_wr_arbiter #(
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_reset_n,
  input  logic [REQ_NUM-1:0]            req,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
  output logic [REQ_NUM-1:0]            ack,
  output logic [REQ_NUM-1:0]            grant,
  output logic                          busy,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full
);

  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [REQ_NUM-1:0]     grant_q, grant_d;
  logic [CNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       cand;
  logic [DATA_WIDTH-1:0]  wr_data_c;

  // First requesting index at or above rr_ptr, wrapping modulo REQ_NUM
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % REQ_NUM);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    wr_data_c = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (grant_q[i]) begin
        wr_data_c = wr_data_c | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q == BURST);
  assign fifo_wr_en   = busy & (|(req & grant_q)) & ~fifo_full;
  assign ack          = fifo_wr_en ? grant_q : '0;
  assign fifo_wr_data = wr_data_c;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_found && !fifo_almost_full) begin
          state_d     = BURST;
          grant_d     = REQ_NUM'(1) << win_idx;
          burst_cnt_d = '0;
          rr_ptr_d    = PTR_W'((32'(win_idx) + 32'd1) % REQ_NUM);
        end
      end
      BURST: begin
        // A written last word takes priority over a simultaneous req drop
        if (fifo_wr_en) begin
          if (burst_cnt_q == CNT_WIDTH'(BURST_LEN - 1)) begin
            state_d     = IDLE;
            grant_d     = '0;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
          end
        end else if (!(|(req & grant_q))) begin
          state_d     = IDLE;
          grant_d     = '0;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a transaction-level
// model of round-robin bursts; a monitor process checks the DUT each cycle.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned BL = 4;

  logic              wr_clk;
  logic              wr_reset_n;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      ack;
  logic [N-1:0]      grant;
  logic              busy;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic              fifo_almost_full;

  fifo_wr_arbiter #(
    .REQ_NUM(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(4)
  ) dut (
    .wr_clk(wr_clk), .wr_reset_n(wr_reset_n), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .busy(busy), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct packed { logic [N-1:0] g; logic wr; } cyc_t;
  typedef struct packed { logic [DW-1:0] d; logic [N-1:0] a; } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];

  int vectors  = 0;
  int failures = 0;
  bit running  = 0;

  // Requester agents and the burst-level reference model
  bit          pend [N];
  int unsigned seq  [N];
  int          owner;
  int          words;
  int          ptr;
  logic [N-1:0] mask;
  int unsigned p_new, p_keep, p_full, p_afull;

  function automatic logic [DW-1:0] word(int i, int unsigned s);
    return DW'(32'h1000 * (i + 1) + s);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    words = 0;
    ptr   = 0;
    wr_q.delete();
    cyc_q.delete();
  endtask

  task automatic drive_cycle();
    logic [N-1:0] g;
    bit wr;
    int w;
    @(negedge wr_clk);
    wr_reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && mask[i] && ($urandom_range(99) < p_new)) pend[i] = 1;
      req[i] = pend[i];
      req_data[i*DW +: DW] = pend[i] ? word(i, seq[i]) : DW'($urandom);
    end
    fifo_full        = ($urandom_range(99) < p_full);
    fifo_almost_full = ($urandom_range(99) < p_afull);

    g  = (owner >= 0) ? N'(1 << owner) : '0;
    wr = (owner >= 0) && req[owner] && !fifo_full;
    cyc_q.push_back('{g: g, wr: wr});
    if (wr) wr_q.push_back('{d: word(owner, seq[owner]), a: g});

    if (owner < 0) begin
      if (req != '0 && !fifo_almost_full) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
        end
        owner = w;
        words = 0;
        ptr   = (w + 1) % N;
      end
    end else if (wr) begin
      words++;
      seq[owner]++;
      pend[owner] = ($urandom_range(99) < p_keep);
      if (words == BL) owner = -1;
    end else if (!req[owner]) begin
      owner = -1;
    end
  endtask

  task automatic run(int cycles);
    for (int c = 0; c < cycles; c++) drive_cycle();
  endtask

  // Reset mid-burst: outputs must drop in the same cycle reset asserts
  task automatic mid_reset();
    int tries = 0;
    while (!(owner >= 0 && words >= 1) && tries < 60) begin
      drive_cycle();
      tries++;
    end
    chk("mid_burst_reached", 32'(tries < 60), 32'd1);
    @(negedge wr_clk);
    req        = '1;
    fifo_full  = 1'b0;
    wr_reset_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_ack",   32'(ack), 32'd0);
    chk("midrst_busy",  32'(busy), 32'd0);
    model_reset();
  endtask

  // Monitor: pops per-cycle expectations and, on each write, the next word
  initial begin
    cyc_t c;
    wr_t  w;
    forever begin
      @(negedge wr_clk);
      #2;
      if (wr_reset_n && running) begin
        if (cyc_q.size() == 0) begin
          chk("cycle_expectation_present", 32'd0, 32'd1);
        end else begin
          c = cyc_q.pop_front();
          chk("grant", 32'(grant), 32'(c.g));
          chk("busy", 32'(busy), 32'(c.g != '0));
          chk("fifo_wr_en", 32'(fifo_wr_en), 32'(c.wr));
        end
        if (fifo_wr_en === 1'b1) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", 32'(fifo_wr_data), 32'hFFFF_FFFF);
          end else begin
            w = wr_q.pop_front();
            chk("wr_data", 32'(fifo_wr_data), 32'(w.d));
            chk("ack", 32'(ack), 32'(w.a));
          end
        end else begin
          chk("ack_idle", 32'(ack), 32'd0);
        end
      end
    end
  end

  initial begin
    wr_reset_n       = 1'b0;
    req              = '1;
    req_data         = '0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1;
      seq[i]  = 0;
    end
    model_reset();
    repeat (2) @(negedge wr_clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    running = 1;

    mask = 4'b0001; p_new = 100; p_keep = 100; p_full = 0;  p_afull = 0;
    run(30);
    mask = 4'b1111;
    run(40);
    p_full = 30;
    run(60);
    p_full = 0; p_afull = 40; p_new = 50; p_keep = 50;
    run(80);
    mask = 4'b0100; p_afull = 70;
    run(30);
    mask = 4'b1111; p_new = 40; p_keep = 60; p_full = 20; p_afull = 20;
    run(300);
    p_new = 100; p_keep = 100; p_full = 0; p_afull = 0;
    mid_reset();
    run(40);
    p_new = 60; p_keep = 40; p_full = 25; p_afull = 10;
    mid_reset();
    run(150);

    @(negedge wr_clk);
    running = 0;
    #3;
    chk("writes_outstanding", 32'(wr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
